// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter.
// Handles one digit per clock, most significant digit first, using a
// multiply-by-ten accumulator. Requests and results use valid/ready
// handshakes, and only one request is in flight at a time.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; in_ready=1
// CONV  | folding one latched digit per cycle into the accumulator
// DONE  | result presented on out_bin/out_err; out_valid=1 until taken
module bcd2bin_seq #(
   parameter int NUM_BCD   = 3,
   parameter int BIT_WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NUM_BCD-1:0]   in_bcd,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [BIT_WIDTH-1:0]   out_bin,
   output logic                   out_err
);

   localparam int               CNT_W    = (NUM_BCD > 1) ? $clog2(NUM_BCD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BCD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state;
   logic [4*NUM_BCD-1:0]   bcd_q;
   logic [BIT_WIDTH-1:0]   acc;
   logic                   err;
   logic [CNT_W-1:0]       cnt;

   logic [3:0]             digit;
   logic [BIT_WIDTH-1:0]   acc_next;
   logic                   err_next;

   // Pick the digit that the counter points at in the latched request.
   always_comb begin
      digit = 4'd0;
      for (int i = 0; i < NUM_BCD; i++) begin
         if (cnt == CNT_W'(i)) begin
            digit = bcd_q[4*i +: 4];
         end
      end
   end

   // acc*10 + digit, truncated to BIT_WIDTH bits. Digits above 9 are used
   // at their raw value; they only raise the error flag.
   always_comb begin
      acc_next = (acc << 3) + (acc << 1) + BIT_WIDTH'(digit);
      err_next = err | (digit > 4'd9);
   end

   // Control FSM, datapath registers and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_bin   <= '0;
         out_err   <= 1'b0;
         acc       <= '0;
         err       <= 1'b0;
         cnt       <= '0;
         bcd_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  bcd_q    <= in_bcd;
                  acc      <= '0;
                  err      <= 1'b0;
                  cnt      <= CNT_LAST;
                  in_ready <= 1'b0;
                  state    <= CONV;
               end
            end
            CONV: begin
               acc <= acc_next;
               err <= err_next;
               if (cnt == '0) begin
                  // Last digit: present the result on the same edge so
                  // latency equals the digit count.
                  out_bin   <= acc_next;
                  out_err   <= err_next;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
